// File: rtl/annealer_pkg.sv
// Shared constants for the fabric/HPS bridge blocks: bus widths, CPU address
// map and the marker value returned when the CPU reads an empty result FIFO.
package annealer_pkg;

  localparam int BUS_WIDTH   = 128;
  localparam int SHORT_WIDTH = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam logic [BUS_WIDTH-1:0] UNDERFLOW_PATTERN = {BUS_WIDTH{1'b1}};

  // Packer phase: LOW waits for the lower half of a bus word, HIGH holds it.
  typedef enum logic {
    PACK_LOW  = 1'b0,
    PACK_HIGH = 1'b1
  } pack_state_t;

endpackage

// File: rtl/dsp_result_readback_sync_fifo.sv
// Single-clock FIFO of WIDTH-bit words with occupancy count and a synchronous
// clear that wins over any same-cycle write or read.
module sync_fifo #(
  parameter int WIDTH      = 128,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full && !clear;
  assign do_rd   = rd_en && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_result_readback.sv
// Result return path: pairs of LANES-wide product pushes are packed into bus
// words, queued in a FIFO and served to the CPU with a fixed one-cycle read
// latency alongside status and a clear control.
module dsp_result_readback
  import annealer_pkg::*;
#(
  parameter int DATA_WIDTH = annealer_pkg::SHORT_WIDTH,
  parameter int LANES      = 4,
  parameter int BUS_WIDTH  = annealer_pkg::BUS_WIDTH,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        prod_valid,
  input  logic [LANES*DATA_WIDTH-1:0] prod_data,
  output logic                        prod_ready,
  input  logic [1:0]                  addr,
  input  logic                        read,
  input  logic                        write,
  input  logic [BUS_WIDTH-1:0]        writedata,
  output logic [BUS_WIDTH-1:0]        readdata,
  output logic                        readdatavalid,
  output logic [9:0]                  leds
);

  localparam int HALF_WIDTH = LANES * DATA_WIDTH;

  pack_state_t             state_q;
  pack_state_t             state_d;
  logic [HALF_WIDTH-1:0]   hold_q;
  logic                    underflow_q;
  logic                    half_pend;
  logic                    push_acc;
  logic                    word_wr;
  logic                    clear_req;
  logic                    data_rd;
  logic                    pop_req;
  logic [BUS_WIDTH-1:0]    fifo_head;
  logic [DEPTH_LOG2:0]     fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [BUS_WIDTH-1:0]    status_word;
  logic [BUS_WIDTH-1:0]    readdata_d;
  logic                    unused_writedata;

  assign unused_writedata = ^writedata[BUS_WIDTH-1:1];

  assign half_pend  = (state_q == PACK_HIGH);
  assign prod_ready = !(fifo_full && half_pend);
  assign push_acc   = prod_valid && prod_ready;
  assign clear_req  = write && (addr == ADDR_CTRL) && writedata[0];
  assign data_rd    = read && (addr == ADDR_DATA);
  assign pop_req    = data_rd && !fifo_empty && !clear_req;
  assign word_wr    = push_acc && half_pend && !clear_req;

  assign leds = {underflow_q, fifo_full, fifo_empty, half_pend, 6'(fifo_count)};

  sync_fifo #(
    .WIDTH      (BUS_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_req),
    .wr_en   (word_wr),
    .wr_data ({prod_data, hold_q}),
    .rd_en   (pop_req),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Packer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PACK_LOW;
    else          state_q <= state_d;
  end

  // Packer next state: alternate halves on each accepted push; clear restarts.
  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = PACK_LOW;
    end else if (push_acc) begin
      state_d = (state_q == PACK_LOW) ? PACK_HIGH : PACK_LOW;
    end
  end

  // Capture the lower half of the next bus word while waiting for its partner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          hold_q <= '0;
    else if (push_acc && !half_pend && !clear_req)         hold_q <= prod_data;
  end

  // Sticky underflow: set by a data read of an empty FIFO, dropped by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      underflow_q <= 1'b0;
    else if (clear_req)                underflow_q <= 1'b0;
    else if (data_rd && fifo_empty)    underflow_q <= 1'b1;
  end

  // Status word as seen by the CPU, packed into the low bits.
  always_comb begin
    status_word = '0;
    status_word[DEPTH_LOG2+4:0] = {underflow_q, fifo_full, fifo_empty, half_pend, fifo_count};
  end

  // CPU read mux, sampled into the response register on the read edge.
  always_comb begin
    readdata_d = '0;
    case (addr)
      ADDR_DATA:   readdata_d = fifo_empty ? UNDERFLOW_PATTERN : fifo_head;
      ADDR_STATUS: readdata_d = status_word;
      default:     readdata_d = '0;
    endcase
  end

  // Registered read response gives the fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= readdata_d;
    end
  end

endmodule

// File: tb/tb_dsp_result_readback.sv
// Directed bench for dsp_result_readback: packing, status, full/backpressure,
// underflow and clear, simultaneous push/pop and asynchronous reset.
module tb_dsp_result_readback;

  logic         clk;
  logic         reset_n;
  logic         prod_valid;
  logic [63:0]  prod_data;
  logic         prod_ready;
  logic [1:0]   addr;
  logic         read;
  logic         write;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         readdatavalid;
  logic [9:0]   leds;

  int total;
  int bad;

  dsp_result_readback dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .prod_valid    (prod_valid),
    .prod_data     (prod_data),
    .prod_ready    (prod_ready),
    .addr          (addr),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .leds          (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] half_val(input int i);
    return 64'hCAFE_0000_0000_0000 + 64'(i);
  endfunction

  // Push one half on the next edge.
  task automatic do_push(input logic [63:0] d);
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = d;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  // Issue one read and return the response sampled just after the edge.
  task automatic do_read(input logic [1:0] a, output logic [127:0] d, output logic v);
    @(negedge clk);
    addr = a;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    d = readdata;
    v = readdatavalid;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [127:0] wd);
    @(negedge clk);
    addr      = a;
    write     = 1'b1;
    writedata = wd;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] d;
    logic         v;
    reset_n = 1'b0;
    #12;
    total++;
    if (leds !== 10'b0010000000) begin bad++; $display("[TB] FAIL reset_leds: got %b expected %b", leds, 10'b0010000000); end
    total++;
    if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", prod_ready); end
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 128'h0) begin bad++; $display("[TB] FAIL reset_read: got v=%b d=%h expected v=0 d=0", readdatavalid, readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    do_read(2'd1, d, v);
    total++;
    if (v !== 1'b1 || d !== 128'h040) begin bad++; $display("[TB] FAIL reset_status: got v=%b d=%h expected v=1 d=040", v, d); end
    @(posedge clk);
    #1;
    total++;
    if (readdatavalid !== 1'b0) begin bad++; $display("[TB] FAIL rdv_pulse: got %b expected 0", readdatavalid); end
  endtask

  task automatic test_pack();
    logic [127:0] d;
    logic         v;
    do_push(64'h0004_0003_0002_0001);
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h060) begin bad++; $display("[TB] FAIL half_status: got %h expected 060", d); end
    do_push(64'h0008_0007_0006_0005);
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h001) begin bad++; $display("[TB] FAIL word_status: got %h expected 001", d); end
    do_read(2'd0, d, v);
    total++;
    if (v !== 1'b1 || d !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin bad++; $display("[TB] FAIL pack_data: got v=%b d=%h expected v=1 d=00080007000600050004000300020001", v, d); end
    do_read(2'd2, d, v);
    total++;
    if (d !== 128'h0) begin bad++; $display("[TB] FAIL ctrl_read: got %h expected 0", d); end
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h040) begin bad++; $display("[TB] FAIL drain_status: got %h expected 040", d); end
  endtask

  task automatic test_full();
    logic [127:0] d;
    logic         v;
    for (int i = 0; i < 33; i++) do_push(half_val(i));
    total++;
    if (prod_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b expected 0", prod_ready); end
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h0B0) begin bad++; $display("[TB] FAIL full_status: got %h expected 0b0", d); end
    total++;
    if (leds !== 10'b0101010000) begin bad++; $display("[TB] FAIL full_leds: got %b expected %b", leds, 10'b0101010000); end
    do_read(2'd0, d, v);
    total++;
    if (d !== 128'hCAFE_0000_0000_0001_CAFE_0000_0000_0000) begin bad++; $display("[TB] FAIL full_head: got %h expected cafe000000000001cafe000000000000", d); end
    total++;
    if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL pop_ready: got %b expected 1", prod_ready); end
    do_push(half_val(33));
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h090) begin bad++; $display("[TB] FAIL refill_status: got %h expected 090", d); end
    do_write(2'd2, 128'h1);
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h040) begin bad++; $display("[TB] FAIL full_clear: got %h expected 040", d); end
  endtask

  task automatic test_underflow();
    logic [127:0] d;
    logic         v;
    do_read(2'd0, d, v);
    total++;
    if (v !== 1'b1 || d !== {128{1'b1}}) begin bad++; $display("[TB] FAIL uf_data: got v=%b d=%h expected all-ones", v, d); end
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h140) begin bad++; $display("[TB] FAIL uf_status: got %h expected 140", d); end
    do_write(2'd2, 128'h0);
    do_write(2'd1, 128'h1);
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h140) begin bad++; $display("[TB] FAIL uf_no_clear: got %h expected 140", d); end
    do_write(2'd2, 128'h1);
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h040) begin bad++; $display("[TB] FAIL uf_cleared: got %h expected 040", d); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    logic         v;
    do_push(64'h1111_1111_1111_1111);
    do_push(64'h2222_2222_2222_2222);
    do_push(64'h3333_3333_3333_3333);
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = 64'h4444_4444_4444_4444;
    addr       = 2'd0;
    read       = 1'b1;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    read       = 1'b0;
    total++;
    if (readdata !== 128'h2222_2222_2222_2222_1111_1111_1111_1111) begin bad++; $display("[TB] FAIL b2b_old_head: got %h expected 22222222222222221111111111111111", readdata); end
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h001) begin bad++; $display("[TB] FAIL b2b_count: got %h expected 001", d); end
    do_read(2'd0, d, v);
    total++;
    if (d !== 128'h4444_4444_4444_4444_3333_3333_3333_3333) begin bad++; $display("[TB] FAIL b2b_new_word: got %h expected 44444444444444443333333333333333", d); end
  endtask

  task automatic test_empty_push_pop();
    logic [127:0] d;
    logic         v;
    do_push(64'h5555_5555_5555_5555);
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = 64'h6666_6666_6666_6666;
    addr       = 2'd0;
    read       = 1'b1;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    read       = 1'b0;
    total++;
    if (readdata !== {128{1'b1}}) begin bad++; $display("[TB] FAIL epp_data: got %h expected all-ones", readdata); end
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h101) begin bad++; $display("[TB] FAIL epp_status: got %h expected 101", d); end
    do_read(2'd0, d, v);
    total++;
    if (d !== 128'h6666_6666_6666_6666_5555_5555_5555_5555) begin bad++; $display("[TB] FAIL epp_word: got %h expected 66666666666666665555555555555555", d); end
    do_write(2'd2, 128'h1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    logic         v;
    for (int i = 0; i < 7; i++) do_push(half_val(i));
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h023) begin bad++; $display("[TB] FAIL mid_status: got %h expected 023", d); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (leds !== 10'b0010000000) begin bad++; $display("[TB] FAIL mid_reset_leds: got %b expected %b", leds, 10'b0010000000); end
    @(negedge clk);
    reset_n = 1'b1;
    do_read(2'd1, d, v);
    total++;
    if (d !== 128'h040) begin bad++; $display("[TB] FAIL mid_after_reset: got %h expected 040", d); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b1;
    prod_valid = 1'b0;
    prod_data  = '0;
    addr       = 2'd0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    test_reset();
    test_pack();
    test_full();
    test_underflow();
    test_back_to_back();
    test_empty_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
